// File: rtl/mbr_register.sv
// Memory Buffer Register: one data word staged between main memory and the CPU.
// Captures dataIn on an enabled rising edge, otherwise holds; valid marks "loaded since reset".
module mbr_register #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             enable,
  output logic [WIDTH-1:0] dataOut,
  output logic             valid
);

  // Load protocol: enable is a per-edge strobe with no back-pressure. Every rising
  // edge with enable=1 (and rst=0) captures dataIn; valid rises with the first load
  // and stays high until the next reset. Reset beats enable on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut <= RESET_VALUE;
      valid   <= 1'b0;
    end else if (enable) begin
      dataOut <= dataIn;
      valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mbr_register.sv
// Self-checking bench for mbr_register: directed test-plan steps followed by a
// randomized phase, all compared against a word-level reference model.
module tb_mbr_register;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] dataIn;
  logic         enable;
  logic [W-1:0] dataOut;
  logic         valid;

  int checks = 0;
  int errors = 0;

  // Reference model: the word last accepted since reset, and whether one exists.
  logic [W-1:0] modelData;
  logic         modelValid;

  mbr_register #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (dataIn),
    .enable  (enable),
    .dataOut (dataOut),
    .valid   (valid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one edge's worth of inputs, advance the model by the register rules,
  // then sample just after the edge.
  task automatic cycle(input string tag, input logic r, input logic e, input logic [W-1:0] d);
    rst    = r;
    enable = e;
    dataIn = d;
    if (r) begin
      modelData  = '0;
      modelValid = 1'b0;
    end else if (e) begin
      modelData  = d;
      modelValid = 1'b1;
    end
    @(posedge clk);
    #1;
    check_word({tag, ".data"}, dataOut, modelData);
    check_bit({tag, ".valid"}, valid, modelValid);
  endtask

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    dataIn     = '0;
    modelData  = '0;
    modelValid = 1'b0;
    @(negedge clk);

    // 1. Reset with enable high and a live data word
    cycle("reset0", 1'b1, 1'b1, 32'hDEADBEEF);
    cycle("reset1", 1'b1, 1'b1, 32'hDEADBEEF);

    // 2. Single load, then hold
    cycle("load1", 1'b0, 1'b1, 32'h00000002);
    for (int i = 0; i < 3; i++) cycle("hold_after_load", 1'b0, 1'b0, 32'h00000002);

    // 3. Data changes while disabled
    for (int v = 3; v <= 7; v++) cycle("hold_din_moves", 1'b0, 1'b0, W'(v));

    // 4. Sequential pulsed loads
    for (int i = 0; i < 20; i++) begin
      cycle("seq_load", 1'b0, 1'b1, 32'h00000002 + W'(i));
      cycle("seq_idle", 1'b0, 1'b0, 32'hFFFF0000 ^ W'(i));
    end
    check_word("seq_final", dataOut, 32'h00000015);

    // 5. Boundary values, back-to-back
    cycle("b2b_ones",  1'b0, 1'b1, 32'hFFFFFFFF);
    cycle("b2b_zeros", 1'b0, 1'b1, 32'h00000000);
    cycle("b2b_mixed", 1'b0, 1'b1, 32'h80000001);

    // Glitch on enable/dataIn between edges, low again before the edge
    rst = 1'b0;
    enable = 1'b1; dataIn = 32'h5A5A5A5A;
    #2;
    enable = 1'b0; dataIn = 32'h0F0F0F0F;
    cycle("glitch", 1'b0, 1'b0, 32'h0F0F0F0F);
    check_word("glitch_abs", dataOut, 32'h80000001);

    // 6. Reset priority mid-operation, then recovery
    cycle("pre_rst_load", 1'b0, 1'b1, 32'h12345678);
    cycle("rst_vs_en",    1'b1, 1'b1, 32'hAAAAAAAA);
    check_word("rst_vs_en_abs", dataOut, 32'h00000000);
    cycle("post_rst_load", 1'b0, 1'b1, 32'hAAAAAAAA);
    check_word("post_rst_abs", dataOut, 32'hAAAAAAAA);

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      logic         r;
      logic         e;
      logic [W-1:0] d;
      r = ($urandom_range(0, 15) == 0);
      e = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 7))
        0:       d = '1;
        1:       d = '0;
        default: d = $urandom();
      endcase
      cycle("rand", r, e, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mbr_register.md
Name: mbr_register

Overview:
Memory Buffer Register (MBR) for the design1 CPU datapath. It holds one data word moving between main memory and the CPU. It captures `dataIn` on a clock edge when `enable` is asserted, and otherwise holds its contents. `dataOut` drives the internal bus and the memory write-data path continuously.

Parameters:
- WIDTH, 32, data word width in bits.
- RESET_VALUE, 0 (WIDTH bits), value loaded into the register by reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- dataIn  input  WIDTH  word to be captured (memory read data or bus data, muxed upstream).
- enable  input  1  load strobe; when high at a rising clk edge, `dataIn` is captured.
- dataOut  output  WIDTH  current register contents, registered output.
- valid  output  1  high once the register has been loaded since the last reset.

Behaviour:
- Single clock domain, one rising-edge register of WIDTH bits plus a 1-bit `valid` flag. No combinational path from `dataIn` to `dataOut`.
- Reset:
  - Synchronous, active-high, sampled at the rising clk edge.
  - When `rst`=1: `dataOut` <= RESET_VALUE (0x00000000 by default), `valid` <= 0.
  - Reset has priority over `enable`. If `rst`=1 and `enable`=1 on the same edge, the reset value wins.
- Load:
  - When `rst`=0 and `enable`=1 at a rising edge: `dataOut` <= `dataIn`, `valid` <= 1.
  - Latency is one cycle. `dataOut` reflects the captured word immediately after the edge and stays stable for the whole following cycle.
- Hold:
  - When `rst`=0 and `enable`=0: `dataOut` and `valid` keep their values.
  - `dataIn` changes while `enable` is low have no effect.
- `enable` is level-sensitive per edge. Holding it high for N cycles captures N consecutive words, each overwriting the previous one (back-to-back loads, no bubble).
- Full-width transfer with no sign extension, truncation or arithmetic. Every bit of `dataIn` maps to the same bit of `dataOut`. All-ones and all-zeros are legal.
- X/Z handling:
  - If `enable` is X/Z at an edge, no loading is required (hold).
  - Before the first reset, the outputs are undefined. Benches must apply `rst` for at least one edge.
- Mid-operation reset clears the register even if a load is in progress. The next enabled edge after `rst` deasserts loads normally.
- Glitches on `dataIn`/`enable` between edges must not affect `dataOut`.

Test Plan:
1. Reset: `rst`=1 for 2 edges with `dataIn`=0xDEADBEEF, `enable`=1 -> `dataOut`=0x00000000, `valid`=0 after each edge.
2. Single load: `rst`=0, `dataIn`=0x00000002, `enable`=1 for one edge, then `enable`=0 -> `dataOut`=0x00000002 and `valid`=1 after that edge, held for 3 following edges.
3. Hold while disabled: from `dataOut`=0x00000002, set `enable`=0 and step `dataIn` through 0x00000003..0x00000007 -> `dataOut` stays 0x00000002.
4. Sequential loads: 20 iterations with `dataIn` = 0x00000002 + i, each pulsing `enable` for one edge then low -> `dataOut` after iteration i equals 0x00000002 + i (0x00000002..0x00000015).
5. Boundary values and back-to-back loads: `enable` held high on consecutive edges with `dataIn`=0xFFFFFFFF, then 0x00000000, then 0x80000001 -> `dataOut` follows each on the next edge.
6. Reset priority mid-operation: `dataOut`=0x12345678, assert `rst`=1 and `enable`=1 with `dataIn`=0xAAAAAAAA on the same edge -> `dataOut`=0x00000000, `valid`=0. Next edge with `rst`=0, `enable`=1 -> `dataOut`=0xAAAAAAAA, `valid`=1.
